// File: rtl/cla_add_sequencer.sv
// -----------------------------------------------------------------------------
// cla_add_sequencer
//   Drives one shared 4-bit carry-lookahead adder slice over a WIDTH-bit add or
//   subtract, one nibble per clock, LSB nibble first. The carry between nibbles
//   is chained through a register. Subtraction is A + ~B + 1: B is inverted when
//   latched and the first carry-in is 1.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start, sub            request (sampled only while idle) and add/sub select
//   op_a, op_b            operands, latched with start
//   busy, done            sequence in progress / one-cycle result-valid pulse
//   result                registered sum/difference, held until the next done
//   carry, overflow, zero flags, updated together with result
//   nib_a, nib_b, nib_cin operands presented to the external adder slice
//   nib_sum, nib_cout     combinational response of the adder slice
// -----------------------------------------------------------------------------
module cla_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic [3:0]       nib_a,
  output logic [3:0]       nib_b,
  output logic             nib_cin,
  input  logic [3:0]       nib_sum,
  input  logic             nib_cout
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bx_r;
  logic             cy_r;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r;
  logic             overflow_r;
  logic             zero_r;
  logic             busy_r;
  logic             done_r;
  logic             last_s;
  logic [WIDTH-1:0] merged_s;

  assign last_s = (state_r == RUN) && (idx_r == IW'(N - 1));

  // Working accumulator with the current slice sum already merged in, so the
  // final nibble is visible to the flag logic on the same edge it is captured.
  always_comb begin
    merged_s = acc_r;
    if (state_r == RUN) begin
      merged_s[4*idx_r +: 4] = nib_sum;
    end else begin
      merged_s = acc_r;
    end
  end

  // Adder slice operands: only driven during RUN, quiet otherwise.
  always_comb begin
    nib_a   = 4'h0;
    nib_b   = 4'h0;
    nib_cin = 1'b0;
    case (state_r)
      RUN: begin
        nib_a   = a_r[4*idx_r +: 4];
        nib_b   = bx_r[4*idx_r +: 4];
        nib_cin = cy_r;
      end
      default: begin
        nib_a   = 4'h0;
        nib_b   = 4'h0;
        nib_cin = 1'b0;
      end
    endcase
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // busy/done registered from the next state so they line up with state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      done_r <= (state_nxt_s == DONE);
    end
  end

  // Operand latch, nibble walk and result/flag capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r        <= {WIDTH{1'b0}};
      bx_r       <= {WIDTH{1'b0}};
      cy_r       <= 1'b0;
      idx_r      <= {IW{1'b0}};
      acc_r      <= {WIDTH{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      carry_r    <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r   <= op_a;
            bx_r  <= op_b ^ {WIDTH{sub}};
            cy_r  <= sub;
            idx_r <= {IW{1'b0}};
            acc_r <= {WIDTH{1'b0}};
          end
        end
        RUN: begin
          acc_r <= merged_s;
          cy_r  <= nib_cout;
          idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
          // Flags compare the latched sign bits, so B is taken post-inversion.
          if (last_s) begin
            result_r   <= merged_s;
            carry_r    <= nib_cout;
            zero_r     <= (merged_s == {WIDTH{1'b0}});
            overflow_r <= (a_r[WIDTH-1] == bx_r[WIDTH-1]) &&
                          (merged_s[WIDTH-1] != a_r[WIDTH-1]);
          end
        end
        default: begin
          cy_r <= cy_r;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign carry    = carry_r;
  assign overflow = overflow_r;
  assign zero     = zero_r;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cla_add_sequencer
//   Directed bench for cla_add_sequencer at WIDTH=8. Models the external 4-bit
//   adder slice as a plain combinational add and checks handshake timing,
//   per-nibble slice operands, results and flags against hand-computed values.
// -----------------------------------------------------------------------------
module tb_cla_add_sequencer;

  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             nib_cin;
  logic [3:0]       nib_sum;
  logic             nib_cout;

  int total;
  int bad;

  cla_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .nib_a    (nib_a),
    .nib_b    (nib_b),
    .nib_cin  (nib_cin),
    .nib_sum  (nib_sum),
    .nib_cout (nib_cout)
  );

  // External 4-bit adder slice.
  assign {nib_cout, nib_sum} = {1'b0, nib_a} + {1'b0, nib_b} + {4'h0, nib_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op from idle, wait (bounded) for done and check latency/result.
  task automatic do_op(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_r, input logic ec, input logic ev, input logic ez);
    int   cyc;
    logic seen;
    sub   = s;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      seen = done;
    end
    chk({tag, "_latency"}, cyc, N);
    chk({tag, "_result"}, result, exp_r);
    chk({tag, "_carry"}, carry, ec);
    chk({tag, "_overflow"}, overflow, ev);
    chk({tag, "_zero"}, zero, ez);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, done, 1'b0);
    chk({tag, "_idle_after"}, busy, 1'b0);
  endtask

  initial begin
    int pulses;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = 8'h00;
    op_b  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_flags", {carry, overflow, zero}, 3'b000);
    chk("rst_nib", {nib_a, nib_b, nib_cin}, 9'h000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: 0x3C + 0x45 = 0x81, signed overflow
    start = 1'b1; sub = 1'b0; op_a = 8'h3C; op_b = 8'h45;
    @(posedge clk); #1;
    start = 1'b0; op_a = 8'hFF; op_b = 8'hFF; sub = 1'b1;
    chk("t1_busy", busy, 1'b1);
    chk("t1_nib0", {nib_a, nib_b, nib_cin}, {4'hC, 4'h5, 1'b0});
    @(posedge clk); #1;
    chk("t1_nib1", {nib_a, nib_b, nib_cin}, {4'h3, 4'h4, 1'b1});
    chk("t1_no_early_done", done, 1'b0);
    @(posedge clk); #1;
    chk("t1_done", done, 1'b1);
    chk("t1_result", result, 8'h81);
    chk("t1_flags_cvz", {carry, overflow, zero}, 3'b010);
    chk("t1_nib_quiet_done", {nib_a, nib_b, nib_cin}, 9'h000);
    @(posedge clk); #1;
    chk("t1_done_drop", done, 1'b0);
    chk("t1_busy_drop", busy, 1'b0);

    // 2: 0xFF + 0x01 wraps to 0 with carry; carry chains into nibble 1
    start = 1'b1; sub = 1'b0; op_a = 8'hFF; op_b = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t2_nib0", {nib_a, nib_b, nib_cin}, {4'hF, 4'h1, 1'b0});
    @(posedge clk); #1;
    chk("t2_nib1", {nib_a, nib_b, nib_cin}, {4'hF, 4'h0, 1'b1});
    chk("t2_prev_held", result, 8'h81);
    @(posedge clk); #1;
    chk("t2_done", done, 1'b1);
    chk("t2_result", result, 8'h00);
    chk("t2_flags_cvz", {carry, overflow, zero}, 3'b101);
    @(posedge clk); #1;

    // 3: 0x10 - 0x01 = 0x0F, inverted B and cin=1 on the first pass
    start = 1'b1; sub = 1'b1; op_a = 8'h10; op_b = 8'h01;
    @(posedge clk); #1;
    start = 1'b0; sub = 1'b0;
    chk("t3_nib0", {nib_a, nib_b, nib_cin}, {4'h0, 4'hE, 1'b1});
    @(posedge clk); #1;
    chk("t3_nib1", {nib_a, nib_b, nib_cin}, {4'h1, 4'hF, 1'b0});
    @(posedge clk); #1;
    chk("t3_done", done, 1'b1);
    chk("t3_result", result, 8'h0F);
    chk("t3_flags_cvz", {carry, overflow, zero}, 3'b100);
    @(posedge clk); #1;

    // 4: borrow and subtract overflow
    do_op("t4a", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    do_op("t4b", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);

    // 5: start while busy is ignored; start after done is accepted
    start = 1'b1; sub = 1'b0; op_a = 8'h11; op_b = 8'h22;
    @(posedge clk); #1;
    start = 1'b1; sub = 1'b1; op_a = 8'h77; op_b = 8'h77;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_nib1_unchanged", {nib_a, nib_b, nib_cin}, {4'h1, 4'h2, 1'b0});
    @(posedge clk); #1;
    chk("t5_done", done, 1'b1);
    chk("t5_result", result, 8'h33);
    start = 1'b1; sub = 1'b0; op_a = 8'h77; op_b = 8'h77;
    @(posedge clk); #1;
    chk("t5_start_in_done_ignored", busy, 1'b0);
    op_a = 8'h05; op_b = 8'h06;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_start_after_done", busy, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_b2b_done", done, 1'b1);
    chk("t5_b2b_result", result, 8'h0B);
    @(posedge clk); #1;

    // 6: reset mid-sequence abandons the op
    start = 1'b1; sub = 1'b0; op_a = 8'h12; op_b = 8'h34;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_result", result, 8'h00);
    chk("t6_flags", {carry, overflow, zero}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("t6_no_done", pulses, 0);
    do_op("t6_after", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
